// File: rtl/vga_timing_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_ctrl_pkg
// Shared VGA constants for the display path: visible resolution, default
// 640x480@60Hz phase lengths, colour constants and the counter type used by
// the timing generator.
// ----------------------------------------------------------------------------
package vga_timing_ctrl_pkg;

  localparam int unsigned VGA_WIDTH  = 640;
  localparam int unsigned VGA_HEIGHT = 480;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BACK  = 48;
  localparam int unsigned DEF_H_FRONT = 16;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BACK  = 33;
  localparam int unsigned DEF_V_FRONT = 10;

  // Deepest renderer pipeline the request window is sized for.
  localparam int unsigned PIX_LAT_MAX = 8;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// vga_timing_ctrl
// VGA timing generator and pixel output stage. Free-running horizontal and
// vertical counters drive a pixel request (coordinates) to the active page
// renderer, which answers PIX_LAT cycles later on pix_data. The returned
// RGB565 value is registered, forced black outside the visible area, and
// presented together with registered hsync/vsync.
//
// Ports
//   vga_clk      in   pixel clock (single domain)
//   sys_rst_n    in   asynchronous active-low reset
//   pix_data     in   RGB565 from renderer, valid PIX_LAT cycles after pix_req
//   pix_req      out  renderer must produce pixel (pix_x, pix_y)
//   pix_x        out  requested column, 10'h3FF when pix_req=0
//   pix_y        out  requested row, 10'h3FF when pix_req=0
//   hsync        out  horizontal sync, active-low, registered
//   vsync        out  vertical sync, active-low, registered
//   rgb          out  RGB565 to the DAC, registered, black when blanked
//   frame_start  out  one-cycle registered pulse for counter position (0,0)
// ----------------------------------------------------------------------------
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BACK  = DEF_H_BACK,
  parameter int unsigned H_VALID = VGA_WIDTH,
  parameter int unsigned H_FRONT = DEF_H_FRONT,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BACK  = DEF_V_BACK,
  parameter int unsigned V_VALID = VGA_HEIGHT,
  parameter int unsigned V_FRONT = DEF_V_FRONT,
  parameter int unsigned PIX_LAT = 1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam cnt_t H_LAST   = cnt_t'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  localparam cnt_t HS       = cnt_t'(H_SYNC + H_BACK);
  localparam cnt_t HE       = cnt_t'(H_SYNC + H_BACK + H_VALID);
  localparam cnt_t VS       = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t VE       = cnt_t'(V_SYNC + V_BACK + V_VALID);
  localparam cnt_t REQ_LO   = cnt_t'(H_SYNC + H_BACK - PIX_LAT);
  localparam cnt_t REQ_HI   = cnt_t'(H_SYNC + H_BACK + H_VALID - PIX_LAT);
  localparam cnt_t HSYNC_HI = cnt_t'(H_SYNC);
  localparam cnt_t VSYNC_HI = cnt_t'(V_SYNC);

  // The request window is shifted left by PIX_LAT; keeping it inside the
  // back porch means a request never straddles a line boundary.
  if (PIX_LAT > H_BACK || PIX_LAT > PIX_LAT_MAX) begin : g_lat_check
    $error("vga_timing_ctrl: PIX_LAT out of range");
  end

  cnt_t cnt_h;
  cnt_t cnt_v;
  logic h_act;
  logic v_act;
  logic h_req;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + cnt_t'(1);
    end else begin
      cnt_h <= cnt_h + cnt_t'(1);
    end
  end

  always_comb begin
    h_act   = (cnt_h >= HS) && (cnt_h < HE);
    v_act   = (cnt_v >= VS) && (cnt_v < VE);
    h_req   = (cnt_h >= REQ_LO) && (cnt_h < REQ_HI);
    pix_req = h_req && v_act;
    pix_x   = pix_req ? (cnt_h - REQ_LO) : '1;
    pix_y   = pix_req ? (cnt_v - VS) : '1;
  end

  // pix_data sampled here answers the request issued PIX_LAT cycles ago, so
  // rgb lines up with the syncs decoded from the same counter value.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= BLACK;
      frame_start <= 1'b0;
    end else begin
      hsync       <= !(cnt_h < HSYNC_HI);
      vsync       <= !(cnt_v < VSYNC_HI);
      rgb         <= (h_act && v_act) ? pix_data : BLACK;
      frame_start <= (cnt_h == '0) && (cnt_v == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_ctrl
// Three DUTs (PIX_LAT 0, 1, 3) share clock and reset. Vertical timing is
// shortened so whole frames fit in a short run; horizontal timing is the
// real 800-cycle line. Each DUT has a model renderer answering with
// {y[5:0], x} after its latency (16'hBEEF when not requested).
// ----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

  localparam int HT     = 800;
  localparam int HSYNC  = 96;
  localparam int HS     = 144;
  localparam int HV     = 640;
  localparam int VSYNC  = 2;
  localparam int VBACK  = 3;
  localparam int VVALID = 4;
  localparam int VFRONT = 2;
  localparam int VT     = VSYNC + VBACK + VVALID + VFRONT;
  localparam int VS     = VSYNC + VBACK;
  localparam int FRAME  = HT * VT;

  logic        vga_clk    = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic        const_mode = 1'b0;
  logic [15:0] pd  [3];
  logic        req [3];
  logic [9:0]  px  [3];
  logic [9:0]  py  [3];
  logic        hs  [3];
  logic        vs  [3];
  logic        fs  [3];
  logic [15:0] rgb [3];

  always #20 vga_clk = ~vga_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [20:0] cur, p0, p1, p2, sel;
    assign cur = {req[g], px[g], py[g]};
    always @(posedge vga_clk) begin
      p0 <= cur;
      p1 <= p0;
      p2 <= p1;
    end
    assign sel = (L == 0) ? cur : ((L == 1) ? p0 : p2);
    assign pd[g] = (const_mode && g == 1) ? 16'h5746 :
                   (sel[20] ? {sel[5:0], sel[19:10]} : 16'hBEEF);

    vga_timing_ctrl #(
      .V_SYNC (VSYNC),
      .V_BACK (VBACK),
      .V_VALID(VVALID),
      .V_FRONT(VFRONT),
      .PIX_LAT(L)
    ) u_dut (
      .vga_clk    (vga_clk),
      .sys_rst_n  (sys_rst_n),
      .pix_data   (pd[g]),
      .pix_req    (req[g]),
      .pix_x      (px[g]),
      .pix_y      (py[g]),
      .hsync      (hs[g]),
      .vsync      (vs[g]),
      .rgb        (rgb[g]),
      .frame_start(fs[g])
    );
  end

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        fs;
    logic        act;
    logic [15:0] rgb;
  } exp_t;

  exp_t sb_q[$];
  int   pos;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Expected registered outputs after the edge taken with counters at p.
  function automatic exp_t model(int p);
    int h = p % HT;
    int v = (p / HT) % VT;
    logic [9:0] xx, yy;
    exp_t e;
    xx = 10'(h - HS);
    yy = 10'(v - VS);
    e.hs  = !(h < HSYNC);
    e.vs  = !(v < VSYNC);
    e.fs  = (h == 0) && (v == 0);
    e.act = (h >= HS) && (h < HS + HV) && (v >= VS) && (v < VS + VVALID);
    e.rgb = e.act ? {yy[5:0], xx} : 16'h0000;
    return e;
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    #1;
    pos++;
  endtask

  task automatic push_and_tick();
    sb_q.push_back(model(pos));
    tick();
  endtask

  task automatic test_reset();
    exp_t e;
    sys_rst_n = 1'b0;
    repeat (4) @(posedge vga_clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({hs[g], vs[g], fs[g], rgb[g], req[g], px[g], py[g]} !== {3'b110, 16'h0000, 1'b0, 10'h3FF, 10'h3FF})
        $display("FAIL reset_vals lat%0d: got hs%b vs%b fs%b rgb%h req%b x%h y%h required hs1 vs1 fs0 rgb0000 req0 x3ff y3ff",
                 g, hs[g], vs[g], fs[g], rgb[g], req[g], px[g], py[g]);
      else n_pass++;
    end
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    pos = 0;
    push_and_tick();
    e = sb_q.pop_front();
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({hs[g], vs[g], fs[g], rgb[g]} !== {e.hs, e.vs, e.fs, e.rgb})
        $display("FAIL first_edge lat%0d: got %h required %h", g,
                 {hs[g], vs[g], fs[g], rgb[g]}, {e.hs, e.vs, e.fs, e.rgb});
      else n_pass++;
    end
  endtask

  task automatic test_request_window();
    int nreq = 0, rows = 0, line_cnt = 0, last_h = -1;
    int rise_h = -1, rise_v = -1, rise_x = -1, rise_y = -1;
    logic prev = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      int h, v;
      tick();
      h = pos % HT;
      v = (pos / HT) % VT;
      for (int g = 0; g < 3; g++) begin
        int lat = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic er;
        logic [9:0] ex, ey;
        er = (h >= HS - lat) && (h < HS + HV - lat) && (v >= VS) && (v < VS + VVALID);
        ex = er ? 10'(h - (HS - lat)) : 10'h3FF;
        ey = er ? 10'(v - VS) : 10'h3FF;
        n_checks++;
        if ({req[g], px[g], py[g]} !== {er, ex, ey})
          $display("FAIL req_window lat%0d h%0d v%0d: got req%b x%0d y%0d required req%b x%0d y%0d",
                   g, h, v, req[g], px[g], py[g], er, ex, ey);
        else n_pass++;
      end
      if (req[1] && !prev && rise_h < 0) begin
        rise_h = h; rise_v = v; rise_x = int'(px[1]); rise_y = int'(py[1]);
      end
      prev = req[1];
      if (req[1]) begin
        nreq++;
        line_cnt++;
        if (px[1] == 10'd639) last_h = h;
      end
      if (h == HT - 1) begin
        if (line_cnt != 0) begin
          rows++;
          n_checks++;
          if (line_cnt !== HV)
            $display("FAIL req_per_line v%0d: got %0d required %0d", v, line_cnt, HV);
          else n_pass++;
        end
        line_cnt = 0;
      end
    end
    n_checks++;
    if ({rise_h, rise_v, rise_x, rise_y} !== {32'd143, 32'(VS), 32'd0, 32'd0})
      $display("FAIL req_rise: got h%0d v%0d x%0d y%0d required h143 v%0d x0 y0",
               rise_h, rise_v, rise_x, rise_y, VS);
    else n_pass++;
    n_checks++;
    if (last_h !== 782) $display("FAIL req_last_h: got %0d required 782", last_h);
    else n_pass++;
    n_checks++;
    if (rows !== VVALID || nreq !== HV * VVALID)
      $display("FAIL req_totals: got rows%0d reqs%0d required rows%0d reqs%0d",
               rows, nreq, VVALID, HV * VVALID);
    else n_pass++;
  endtask

  task automatic test_data_alignment();
    for (int i = 0; i < FRAME; i++) begin
      exp_t e;
      int h, v;
      h = pos % HT;
      v = (pos / HT) % VT;
      push_and_tick();
      e = sb_q.pop_front();
      for (int g = 0; g < 3; g++) begin
        n_checks++;
        if ({hs[g], vs[g], fs[g], rgb[g]} !== {e.hs, e.vs, e.fs, e.rgb})
          $display("FAIL align lat%0d h%0d v%0d: got %h required %h", g, h, v,
                   {hs[g], vs[g], fs[g], rgb[g]}, {e.hs, e.vs, e.fs, e.rgb});
        else n_pass++;
        if (h == HS && v == VS) begin
          n_checks++;
          if (rgb[g] !== 16'h0000) $display("FAIL first_pixel lat%0d: got %h required 0000", g, rgb[g]);
          else n_pass++;
        end
        if (h == HS + 5 && v == VS + 2) begin
          n_checks++;
          if (rgb[g] !== 16'h0805) $display("FAIL pixel_5_2 lat%0d: got %h required 0805", g, rgb[g]);
          else n_pass++;
        end
        if (h == HS + HV && v == VS) begin
          n_checks++;
          if (rgb[g] !== 16'h0000) $display("FAIL blank_784 lat%0d: got %h required 0000", g, rgb[g]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_line_timing();
    int low [3];
    int edges = 0, last_edge = -1;
    logic prev;
    low  = '{0, 0, 0};
    prev = hs[1];
    for (int i = 0; i < 3 * HT; i++) begin
      tick();
      for (int g = 0; g < 3; g++) if (!hs[g]) low[g]++;
      if (prev && !hs[1]) begin
        if (last_edge >= 0) begin
          n_checks++;
          if (pos - last_edge !== HT)
            $display("FAIL hsync_period: got %0d required %0d", pos - last_edge, HT);
          else n_pass++;
        end
        last_edge = pos;
        edges++;
      end
      prev = hs[1];
    end
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (low[g] !== 3 * HSYNC) $display("FAIL hsync_low lat%0d: got %0d required %0d", g, low[g], 3 * HSYNC);
      else n_pass++;
    end
    n_checks++;
    if (edges !== 3) $display("FAIL hsync_edges: got %0d required 3", edges);
    else n_pass++;
  endtask

  task automatic test_frame_timing();
    int vlow = 0, pulses = 0, last_fs = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (!vs[1]) vlow++;
      if (fs[1]) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (pos - last_fs !== FRAME)
            $display("FAIL frame_period: got %0d required %0d", pos - last_fs, FRAME);
          else n_pass++;
        end
        last_fs = pos;
        pulses++;
      end
    end
    n_checks++;
    if (vlow !== 2 * VSYNC * HT) $display("FAIL vsync_low: got %0d required %0d", vlow, 2 * VSYNC * HT);
    else n_pass++;
    n_checks++;
    if (pulses !== 2) $display("FAIL frame_pulses: got %0d required 2", pulses);
    else n_pass++;
  endtask

  task automatic test_blank_gating();
    int n_col = 0;
    const_mode = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      exp_t e;
      logic [15:0] want;
      push_and_tick();
      e = sb_q.pop_front();
      want = e.act ? 16'h5746 : 16'h0000;
      if (rgb[1] === 16'h5746) n_col++;
      n_checks++;
      if (rgb[1] !== want) $display("FAIL gating pos%0d: got %h required %h", pos, rgb[1], want);
      else n_pass++;
    end
    n_checks++;
    if (n_col !== HV * VVALID) $display("FAIL gating_count: got %0d required %0d", n_col, HV * VVALID);
    else n_pass++;
  endtask

  task automatic test_midframe_reset();
    logic found = 1'b0;
    for (int i = 0; i < FRAME + 1; i++) begin
      if (pos % HT == 400 && (pos / HT) % VT == 7) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!found) $display("FAIL reset_point: got not_reached required (400,7)");
    else n_pass++;
    n_checks++;
    if (rgb[1] !== 16'h5746) $display("FAIL pre_reset_rgb: got %h required 5746", rgb[1]);
    else n_pass++;
    sys_rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({hs[g], vs[g], fs[g], rgb[g], req[g], px[g], py[g]} !== {3'b110, 16'h0000, 1'b0, 10'h3FF, 10'h3FF})
        $display("FAIL midreset_vals lat%0d: got hs%b vs%b fs%b rgb%h req%b x%h y%h required hs1 vs1 fs0 rgb0000 req0 x3ff y3ff",
                 g, hs[g], vs[g], fs[g], rgb[g], req[g], px[g], py[g]);
      else n_pass++;
    end
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    pos = 0;
    for (int i = 0; i < (VS + 1) * HT; i++) begin
      exp_t e;
      push_and_tick();
      e = sb_q.pop_front();
      for (int g = 0; g < 3; g++) begin
        logic [15:0] want;
        want = (g == 1) ? (e.act ? 16'h5746 : 16'h0000) : e.rgb;
        n_checks++;
        if ({hs[g], vs[g], fs[g], rgb[g]} !== {e.hs, e.vs, e.fs, want})
          $display("FAIL restart lat%0d pos%0d: got %h required %h", g, pos - 1,
                   {hs[g], vs[g], fs[g], rgb[g]}, {e.hs, e.vs, e.fs, want});
        else n_pass++;
      end
    end
  endtask

  initial begin
    pos = 0;
    test_reset();
    test_request_window();
    test_data_alignment();
    test_line_timing();
    test_frame_timing();
    test_blank_gating();
    test_midframe_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
